// File: rtl/ram_dump_uart_ctrl_pkg.sv
// Shared types and constants for the RAM window dump over UART.
// FSM state encoding, ASCII constants and the nibble-to-hex helper.
package ram_dump_uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_LOAD_BYTE,
        ST_SEND,
        ST_NEXT
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_0 + {4'h0, n};
        return ASCII_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/ram_dump_uart_ctrl_tx.sv
// UART 8N1 serialiser: start bit, 8 data bits LSB first, stop bit.
// Ports: clk, reset, tx_start, tx_byte, tx_busy, tx_done (last stop cycle), tx.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
    // tx_done marks the final cycle of the stop bit so a new frame can
    // start on the very next cycle without an idle gap.
    assign tx_done = tx_busy && bit_end && (bit_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (tx_start && (!tx_busy || tx_done)) begin
            tx_busy <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, tx_byte};
            tx      <= 1'b0;
        end else if (tx_busy) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ram_dump_uart_ctrl.sv
// Dumps a RAM address window over UART 8N1, raw bytes or ASCII hex + CR LF.
// Ports: start edge, first/last_addr window, ram req/gnt/addr/rdata, busy, done, uart_tx.
module ram_dump_uart_ctrl
    import ram_dump_uart_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int HEX_MODE     = 0,
    parameter int LSB_FIRST    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  ram_gnt,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  uart_tx
);

    localparam int NBYTE = DATA_WIDTH / 8;
    localparam int NNIB  = DATA_WIDTH / 4;
    localparam int NSYM  = (HEX_MODE != 0) ? NNIB + 2 : NBYTE;

    state_t                state;
    logic                  start_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [4:0]            sym_idx;
    logic [63:0]           word_ext;
    logic [7:0]            sym;
    logic                  last_sym;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  tx_done;
    int                    idx;
    int                    p;

    assign word_ext = 64'(word_reg);
    assign last_sym = (int'(sym_idx) == NSYM - 1);

    // In SEND the serialiser is fed the following symbol so frames chain
    // back to back; LOAD_BYTE issues the first symbol of each word.
    assign tx_start = (state == ST_LOAD_BYTE && !tx_busy) ||
                      (state == ST_SEND && tx_done && !last_sym);

    always_comb begin
        idx = int'(sym_idx) + ((state == ST_SEND) ? 1 : 0);
        p   = 0;
        sym = 8'h00;
        if (HEX_MODE != 0) begin
            if (idx < NNIB) begin
                p   = (LSB_FIRST != 0) ? idx : NNIB - 1 - idx;
                sym = hex_ascii(4'(word_ext >> (4 * p)));
            end else if (idx == NNIB) begin
                sym = ASCII_CR;
            end else begin
                sym = ASCII_LF;
            end
        end else begin
            p   = (LSB_FIRST != 0) ? idx : NBYTE - 1 - idx;
            sym = 8'(word_ext >> (8 * p));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b1;
            cur_addr  <= '0;
            end_addr  <= '0;
            word_reg  <= '0;
            sym_idx   <= '0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !start_q) begin
                        cur_addr  <= first_addr;
                        end_addr  <= last_addr;
                        ram_addr  <= first_addr;
                        ram_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ram_gnt) begin
                        ram_rd_en <= 1'b0;
                        state     <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    word_reg <= ram_rdata;
                    sym_idx  <= '0;
                    state    <= ST_LOAD_BYTE;
                end
                ST_LOAD_BYTE: begin
                    if (!tx_busy)
                        state <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_done) begin
                        if (last_sym)
                            state <= ST_NEXT;
                        else
                            sym_idx <= sym_idx + 5'd1;
                    end
                end
                ST_NEXT: begin
                    if (cur_addr == end_addr) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cur_addr  <= cur_addr + 1'b1;
                        ram_addr  <= cur_addr + 1'b1;
                        ram_rd_en <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_byte (sym),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx      (uart_tx)
    );

endmodule

// File: tb/tb_ram_dump_uart_ctrl.sv
// Bench for ram_dump_uart_ctrl: raw MSB-first and hex LSB-first instances.
// Scoreboard of expected reads and UART bytes, checked by decoding monitors.
module tb_ram_dump_uart_ctrl;

    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] b;
        bit         chained;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          start[2];
    logic [AW-1:0] fa[2];
    logic [AW-1:0] la[2];
    logic [AW-1:0] ra[2];
    logic          gnt[2];
    logic          rd_en[2];
    logic          cpu[2];
    logic          bsy[2];
    logic          dn[2];
    logic          tx[2];
    logic [DW-1:0] rdata[2];
    bit            hold[2];
    bit            contend;
    logic [DW-1:0] mem[64];

    exp_t q[2][$];
    int   aq[2][$];
    int   done_cnt[2];
    bit   rst_seen[2];
    int   checks = 0;
    int   failures = 0;

    ram_dump_uart_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB),
        .HEX_MODE(0), .LSB_FIRST(0)
    ) dut_raw (
        .clk(clk), .reset(reset), .start(start[0]),
        .first_addr(fa[0]), .last_addr(la[0]), .ram_gnt(gnt[0]),
        .ram_rd_en(rd_en[0]), .ram_addr(ra[0]), .ram_rdata(rdata[0]),
        .busy(bsy[0]), .done(dn[0]), .uart_tx(tx[0])
    );

    ram_dump_uart_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB),
        .HEX_MODE(1), .LSB_FIRST(1)
    ) dut_hex (
        .clk(clk), .reset(reset), .start(start[1]),
        .first_addr(fa[1]), .last_addr(la[1]), .ram_gnt(gnt[1]),
        .ram_rd_en(rd_en[1]), .ram_addr(ra[1]), .ram_rdata(rdata[1]),
        .busy(bsy[1]), .done(dn[1]), .uart_tx(tx[1])
    );

    // Arbitration as at top level: CPU activity blocks the grant.
    assign gnt[0] = rd_en[0] & ~cpu[0];
    assign gnt[1] = rd_en[1] & ~cpu[1];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++)
            cpu[k] = hold[k] | (contend && $urandom_range(3) == 0);
    end

    // One-cycle latency RAM; data is garbage outside the cycle after a read.
    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            rdata[k] <= (rd_en[k] && gnt[k]) ? mem[ra[k]] : DW'($urandom);

    always @(negedge clk)
        for (int k = 0; k < 2; k++)
            if (dn[k] === 1'b1) done_cnt[k]++;

    always @(posedge clk)
        if (reset) begin
            rst_seen[0] = 1'b1;
            rst_seen[1] = 1'b1;
        end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic bad_event(input string nm, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
    endtask

    task automatic uart_mon(input int k);
        logic [7:0] b;
        logic       bad;
        int         t0;
        int         last_start;
        exp_t       e;
        last_start = -1000;
        forever begin
            @(negedge clk);
            if (tx[k] === 1'b0) begin
                t0 = cyc;
                rst_seen[k] = 1'b0;
                repeat (2) @(negedge clk);
                bad = (tx[k] !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx[k];
                end
                repeat (CPB) @(negedge clk);
                if (tx[k] !== 1'b1) bad = 1'b1;
                if (!rst_seen[k]) begin
                    if (q[k].size() == 0) begin
                        bad_event($sformatf("uart%0d_unexpected", k), b);
                    end else begin
                        e = q[k].pop_front();
                        chk($sformatf("uart%0d_byte", k), b, e.b);
                        chk($sformatf("uart%0d_frame", k), bad, 0);
                        if (e.chained)
                            chk($sformatf("uart%0d_gap", k),
                                t0 - last_start, 10 * CPB);
                    end
                end
                last_start = t0;
            end
        end
    endtask

    task automatic rd_mon(input int k);
        forever begin
            @(negedge clk);
            if (rd_en[k] === 1'b1 && gnt[k] === 1'b1) begin
                if (aq[k].size() == 0)
                    bad_event($sformatf("rd%0d_unexpected", k), ra[k]);
                else
                    chk($sformatf("rd%0d_addr", k), ra[k], aq[k].pop_front());
            end
        end
    endtask

    initial uart_mon(0);
    initial uart_mon(1);
    initial rd_mon(0);
    initial rd_mon(1);

    // Reference model: instance 0 sends bytes MSB first, instance 1 sends
    // hex digits least-significant first followed by CR LF.
    task automatic push_word(input int k, input int w);
        exp_t e;
        int   d;
        if (k == 0) begin
            for (int i = 0; i < DW / 8; i++) begin
                e.b = 8'((w >> (8 * (DW / 8 - 1 - i))) % 256);
                e.chained = (i > 0);
                q[k].push_back(e);
            end
        end else begin
            for (int i = 0; i < DW / 4; i++) begin
                d = (w >> (4 * i)) % 16;
                e.b = 8'((d < 10) ? 48 + d : 55 + d);
                e.chained = (i > 0);
                q[k].push_back(e);
            end
            e.chained = 1'b1;
            e.b = 8'd13;
            q[k].push_back(e);
            e.b = 8'd10;
            q[k].push_back(e);
        end
    endtask

    task automatic push_window(input int k, input int f, input int l);
        int a;
        a = f;
        forever begin
            aq[k].push_back(a);
            push_word(k, int'(mem[a]));
            if (a == l) break;
            a = (a + 1) % 64;
        end
    endtask

    task automatic dump(input int k, input int f, input int l);
        fa[k] = AW'(f);
        la[k] = AW'(l);
        push_window(k, f, l);
        @(negedge clk);
        start[k] = 1'b1;
        repeat (3) @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp);
        for (int i = 0; i < 20000 && done_cnt[k] < exp; i++)
            @(negedge clk);
        chk($sformatf("done%0d_count", k), done_cnt[k], exp);
        repeat (4) @(negedge clk);
        chk($sformatf("busy%0d_after", k), bsy[k], 0);
        chk($sformatf("bytes%0d_left", k), q[k].size(), 0);
        chk($sformatf("reads%0d_left", k), aq[k].size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f;
        int l;
        int k;
        for (int a = 0; a < 64; a++) mem[a] = DW'($urandom);
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            fa[i] = '0;
            la[i] = '0;
            hold[i] = 1'b0;
        end
        contend = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_en", rd_en[i], 0);
            chk("rst_addr", ra[i], 0);
            chk("rst_busy", bsy[i], 0);
            chk("rst_done", dn[i], 0);
            chk("rst_tx", tx[i], 1);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        mem[5] = 16'h12AB;
        dump(0, 5, 5);
        wait_done(0, 1);

        mem[0] = 16'h00F3;
        dump(1, 0, 0);
        wait_done(1, 1);

        contend = 1'b1;
        dump(0, 62, 1);
        wait_done(0, 2);
        contend = 1'b0;

        hold[0] = 1'b1;
        dump(0, 10, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_rd_en", rd_en[0], 1);
            chk("hold_addr", ra[0], 10);
            chk("hold_tx", tx[0], 1);
        end
        hold[0] = 1'b0;
        wait_done(0, 3);

        d0 = done_cnt[0];
        dump(0, 20, 21);
        for (int i = 0; i < 2000 && tx[0] !== 1'b0; i++) @(negedge clk);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tx", tx[0], 1);
        chk("abort_busy", bsy[0], 0);
        chk("abort_rd_en", rd_en[0], 0);
        q[0].delete();
        aq[0].delete();
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_cnt[0], d0);
        dump(0, 20, 20);
        wait_done(0, d0 + 1);

        d0 = done_cnt[0];
        start[0] = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_busy", bsy[0], 0);
        chk("held_no_done", done_cnt[0], d0);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        dump(0, 30, 31);
        repeat (30) @(negedge clk);
        start[0] = 1'b1;
        repeat (3) @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, d0 + 1);
        repeat (300) @(negedge clk);
        chk("one_dump_per_edge", done_cnt[0], d0 + 1);

        for (int r = 0; r < 6; r++) begin
            k = r % 2;
            f = $urandom_range(63);
            l = (f + $urandom_range(2)) % 64;
            for (int a = 0; a < 64; a++) mem[a] = DW'($urandom);
            contend = $urandom_range(1) == 1;
            d0 = done_cnt[k];
            dump(k, f, l);
            wait_done(k, d0 + 1);
        end
        contend = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
